// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART RX frame checker
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } frm_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 8;

endpackage

// File: rtl/uart_rx_frame_check_if.sv
// rtl/uart_rx_frame_check_if.sv - sampled-bit stream and per-frame config from the RX sampler/FSM
interface uart_rx_frame_check_if;

    logic frm_start;
    logic bit_en;
    logic sampled_bit;
    logic par_en;
    logic par_typ;
    logic two_stop;

    modport master (
        output frm_start, bit_en, sampled_bit, par_en, par_typ, two_stop
    );

    modport slave (
        input frm_start, bit_en, sampled_bit, par_en, par_typ, two_stop
    );

endinterface

// File: rtl/uart_rx_sat_counter.sv
// rtl/uart_rx_sat_counter.sv - saturating up-counter with synchronous clear priority
module uart_rx_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_frame_check.sv
// rtl/uart_rx_frame_check.sv - per-frame parity/stop checker with done pulse and error counters
module uart_rx_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_rx_frame_check_if.slave  rx,
    input  logic                  cnt_clr,
    output logic                  busy,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  frm_done,
    output logic                  frm_ok,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

    localparam int BW = $clog2(DATA_WIDTH);

    frm_state_e    state;
    logic [BW-1:0] bit_cnt;
    logic          acc;
    logic          par_en_l;
    logic          par_typ_l;
    logic          two_stop_l;
    logic          par_calc;
    logic          stp_final;

    assign busy      = (state != ST_IDLE);
    assign par_calc  = (acc ^ rx.sampled_bit) ? PAR_ODD : PAR_EVEN;
    assign stp_final = stp_err | ~rx.sampled_bit;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            acc        <= 1'b0;
            par_en_l   <= 1'b0;
            par_typ_l  <= 1'b0;
            two_stop_l <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            frm_done   <= 1'b0;
            frm_ok     <= 1'b0;
        end else begin
            frm_done <= 1'b0;
            frm_ok   <= 1'b0;
            // A new start always wins, which also aborts any frame in flight.
            if (rx.frm_start) begin
                state      <= ST_DATA;
                bit_cnt    <= '0;
                acc        <= 1'b0;
                par_en_l   <= rx.par_en;
                par_typ_l  <= rx.par_typ;
                two_stop_l <= rx.two_stop;
                par_err    <= 1'b0;
                stp_err    <= 1'b0;
            end else if (rx.bit_en) begin
                case (state)
                    ST_DATA: begin
                        acc     <= acc ^ rx.sampled_bit;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            state <= par_en_l ? ST_PARITY : ST_STOP1;
                        end
                    end
                    ST_PARITY: begin
                        par_err <= (par_calc != par_typ_l);
                        state   <= ST_STOP1;
                    end
                    ST_STOP1: begin
                        stp_err <= ~rx.sampled_bit;
                        if (two_stop_l) begin
                            state <= ST_STOP2;
                        end else begin
                            state    <= ST_IDLE;
                            frm_done <= 1'b1;
                            frm_ok   <= ~par_err & rx.sampled_bit;
                        end
                    end
                    ST_STOP2: begin
                        stp_err  <= stp_final;
                        state    <= ST_IDLE;
                        frm_done <= 1'b1;
                        frm_ok   <= ~par_err & ~stp_final;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    uart_rx_sat_counter #(.WIDTH(CNT_WIDTH)) u_par_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (cnt_clr),
        .inc   (frm_done & par_err),
        .count (par_err_cnt)
    );

    uart_rx_sat_counter #(.WIDTH(CNT_WIDTH)) u_stp_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (cnt_clr),
        .inc   (frm_done & stp_err),
        .count (stp_err_cnt)
    );

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb/tb_uart_rx_frame_check.sv - directed self-checking bench for uart_rx_frame_check
module tb_uart_rx_frame_check;

    logic       CLK;
    logic       RST;
    logic       cnt_clr;
    logic       busy, par_err, stp_err, frm_done, frm_ok;
    logic [7:0] par_err_cnt, stp_err_cnt;
    logic       busy2, par_err2, stp_err2, frm_done2, frm_ok2;
    logic [1:0] par_err_cnt2, stp_err_cnt2;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;
    int done_base;

    uart_rx_frame_check_if rx_if ();

    uart_rx_frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .rx(rx_if), .cnt_clr(cnt_clr),
        .busy(busy), .par_err(par_err), .stp_err(stp_err),
        .frm_done(frm_done), .frm_ok(frm_ok),
        .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
    );

    uart_rx_frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut2 (
        .CLK(CLK), .RST(RST), .rx(rx_if), .cnt_clr(cnt_clr),
        .busy(busy2), .par_err(par_err2), .stp_err(stp_err2),
        .frm_done(frm_done2), .frm_ok(frm_ok2),
        .par_err_cnt(par_err_cnt2), .stp_err_cnt(stp_err_cnt2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) if (frm_done === 1'b1) done_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_frame(input logic pe, input logic pt, input logic ts);
        @(negedge CLK);
        rx_if.frm_start = 1'b1;
        rx_if.par_en    = pe;
        rx_if.par_typ   = pt;
        rx_if.two_stop  = ts;
        @(negedge CLK);
        rx_if.frm_start = 1'b0;
    endtask

    // Ends on the negedge after the capturing edge, i.e. inside a frm_done cycle.
    task automatic send_bit(input logic b);
        @(negedge CLK);
        rx_if.bit_en      = 1'b1;
        rx_if.sampled_bit = b;
        @(negedge CLK);
        rx_if.bit_en      = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic stop_err_frame();
        start_frame(1'b0, 1'b0, 1'b0);
        send_data(8'h55);
        send_bit(1'b0);
    endtask

    initial begin
        RST = 1'b0;
        cnt_clr = 1'b0;
        rx_if.frm_start = 1'b0;
        rx_if.bit_en = 1'b0;
        rx_if.sampled_bit = 1'b1;
        rx_if.par_en = 1'b0;
        rx_if.par_typ = 1'b0;
        rx_if.two_stop = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frm_done), 32'd0);
        check("rst_pcnt", 32'(par_err_cnt), 32'd0);
        RST = 1'b1;

        // 1: asynchronous reset mid-frame
        start_frame(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("t1_busy_pre", 32'(busy), 32'd1);
        #2 RST = 1'b0;
        #1;
        check("t1_busy_async", 32'(busy), 32'd0);
        check("t1_flags_async", {30'd0, par_err, stp_err}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        done_base = done_seen;
        for (int i = 0; i < 12; i++) send_bit(1'b0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_done", 32'(done_seen - done_base), 32'd0);

        // 2: even parity, 0xA5, good parity and stop
        start_frame(1'b1, 1'b0, 1'b0);
        send_data(8'hA5);
        send_bit(1'b0);
        check("t2_done_early", 32'(frm_done), 32'd0);
        send_bit(1'b1);
        check("t2_done", 32'(frm_done), 32'd1);
        check("t2_ok", 32'(frm_ok), 32'd1);
        check("t2_errs", {30'd0, par_err, stp_err}, 32'd0);
        @(negedge CLK);
        check("t2_done_pulse", 32'(frm_done), 32'd0);
        check("t2_ok_low", 32'(frm_ok), 32'd0);
        check("t2_cnts", {par_err_cnt, stp_err_cnt}, 32'd0);

        // 3: odd parity, 0x01, parity bit 1 is wrong
        start_frame(1'b1, 1'b1, 1'b0);
        send_data(8'h01);
        send_bit(1'b1);
        send_bit(1'b1);
        check("t3_done", 32'(frm_done), 32'd1);
        check("t3_par_err", 32'(par_err), 32'd1);
        check("t3_ok", 32'(frm_ok), 32'd0);
        @(negedge CLK);
        check("t3_pcnt", 32'(par_err_cnt), 32'd1);
        check("t3_scnt", 32'(stp_err_cnt), 32'd0);
        check("t3_par_hold", 32'(par_err), 32'd1);

        // 4: no parity, two stop bits
        start_frame(1'b0, 1'b0, 1'b1);
        check("t4_par_cleared", 32'(par_err), 32'd0);
        send_data(8'h00);
        send_bit(1'b1);
        check("t4_stop1_nodone", 32'(frm_done), 32'd0);
        send_bit(1'b0);
        check("t4_done", 32'(frm_done), 32'd1);
        check("t4_stp_err", 32'(stp_err), 32'd1);
        check("t4_par_err", 32'(par_err), 32'd0);
        @(negedge CLK);
        check("t4_scnt1", 32'(stp_err_cnt), 32'd1);
        start_frame(1'b0, 1'b0, 1'b1);
        send_data(8'hFF);
        send_bit(1'b0);
        send_bit(1'b1);
        check("t4b_stp_err", 32'(stp_err), 32'd1);
        @(negedge CLK);
        check("t4b_scnt2", 32'(stp_err_cnt), 32'd2);
        check("t4b_pcnt", 32'(par_err_cnt), 32'd1);

        // 5: abort after 3 bits, then good frame 0x3C
        done_base = done_seen;
        start_frame(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        start_frame(1'b1, 1'b0, 1'b0);
        send_data(8'h3C);
        send_bit(1'b0);
        send_bit(1'b1);
        check("t5_ok", 32'(frm_ok), 32'd1);
        @(negedge CLK);
        check("t5_one_done", 32'(done_seen - done_base), 32'd1);
        check("t5_cnts", {par_err_cnt, stp_err_cnt}, {8'd1, 8'd2});

        // 6: saturation on the 2-bit instance, clear beats increment
        @(negedge CLK);
        cnt_clr = 1'b1;
        @(negedge CLK);
        cnt_clr = 1'b0;
        check("t6_cleared", {par_err_cnt2, stp_err_cnt2}, 32'd0);
        for (int i = 0; i < 5; i++) stop_err_frame();
        @(negedge CLK);
        check("t6_sat", 32'(stp_err_cnt2), 32'd3);
        check("t6_wide", 32'(stp_err_cnt), 32'd5);
        stop_err_frame();
        check("t6_done", 32'(frm_done2), 32'd1);
        cnt_clr = 1'b1;
        @(negedge CLK);
        cnt_clr = 1'b0;
        check("t6_clr_wins", 32'(stp_err_cnt2), 32'd0);
        check("t6_clr_wide", 32'(stp_err_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_check.md
Name: uart_rx_frame_check

Overview:
Parametrised frame-integrity checker for the UART receiver. It replaces the single-bit stop check with a per-frame checker that covers four things: a running parity check over DATA_WIDTH data bits, 1 or 2 stop bits, per-frame error flags with a done pulse, and saturating error counters for status reporting. It sits beside the RX deserializer and consumes the same sampled_bit and strobe stream from the RX sampler and FSM.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal 5..9)
CNT_WIDTH, 8, width of each saturating error counter (legal >= 2)

Ports:
CLK  in  1  system clock, all logic on posedge
RST  in  1  asynchronous active-low reset
frm_start  in  1  pulse: start bit accepted, new frame begins
bit_en  in  1  strobe: sampled_bit is valid for the current frame position
sampled_bit  in  1  majority-sampled RX bit
par_en  in  1  parity bit present (latched at frm_start)
par_typ  in  1  0 = even, 1 = odd (latched at frm_start)
two_stop  in  1  1 = two stop bits (latched at frm_start)
cnt_clr  in  1  synchronous clear of both counters
busy  out  1  frame in progress (state != IDLE)
par_err  out  1  parity error of last completed/current frame
stp_err  out  1  stop error of last completed/current frame
frm_done  out  1  one-cycle pulse when final stop bit is checked
frm_ok  out  1  valid with frm_done: ~par_err & ~stp_err
par_err_cnt  out  CNT_WIDTH  saturating count of frames with parity error
stp_err_cnt  out  CNT_WIDTH  saturating count of frames with stop error

Behaviour:
- Reset: all outputs 0, state IDLE, bit_cnt 0, parity accumulator 0, latched config 0.
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2.
- frm_start in any state:
  - go to DATA.
  - Latch par_en, par_typ, two_stop.
  - Clear bit_cnt, the accumulator, par_err and stp_err.
  - A bit_en in the same cycle is ignored.
- Abort: frm_start while busy aborts the frame. No frm_done is issued and the counters are unchanged.
- IDLE: bit_en ignored.
- DATA:
  - Each bit_en XORs sampled_bit into the accumulator and increments bit_cnt.
  - On the bit_en with bit_cnt == DATA_WIDTH-1, go to PARITY if latched par_en, else STOP1.
- PARITY: on bit_en, par_err <= (acc ^ sampled_bit) != par_typ_l; go to STOP1.
- STOP1: on bit_en, stp_err <= ~sampled_bit. If two_stop_l, go to STOP2; else finish.
- STOP2: on bit_en, stp_err <= stp_err | ~sampled_bit; finish.
- Finish:
  - On the edge after the final bit_en, go to IDLE and assert frm_done for 1 cycle.
  - par_err and stp_err hold their final values from that cycle onward.
  - frm_ok = ~par_err & ~stp_err while frm_done is high, else 0.
  - Error flags hold until the next frm_start.
- Counters:
  - On the cycle after frm_done, increment par_err_cnt if par_err and stp_err_cnt if stp_err.
  - Counters saturate at all-ones (no wrap).
  - cnt_clr zeroes both counters and wins over a simultaneous increment.
- With bit_en absent, state holds indefinitely. No internal timeout.

Decomposition:
- uart_rx_pkg holds:
  - frame-check state enum (IDLE, DATA, PARITY, STOP1, STOP2)
  - parity type constants PAR_EVEN = 0, PAR_ODD = 1
  - default DATA_WIDTH and CNT_WIDTH constants
- One sub-module, uart_rx_sat_counter: parameter WIDTH; inputs CLK, RST, clr, inc; output count. Saturating increment, clr priority. Instantiated twice.

Test Plan:
1. Assert RST mid-frame (after 4 data bits) -> all outputs 0 asynchronously; bit_en after release is ignored until frm_start.
2. Even parity, 1 stop, data 0xA5 LSB first, parity 0, stop 1 -> frm_done 1 cycle after stop bit_en, frm_ok=1, par_err=0, stp_err=0, counters stay 0.
3. Odd parity, data 0x01, parity bit 1 -> par_err=1, frm_ok=0, par_err_cnt=1 the next cycle, stp_err_cnt=0.
4. par_en=0, two_stop=1, stops 1 then 0 -> no parity slot consumed, stp_err=1 after STOP2, stp_err_cnt=1. A second frame with stops 0 then 1 -> stp_err_cnt=2.
5. frm_start after 3 data bits, then a full good frame 0x3C -> exactly one frm_done with frm_ok=1, no counter change.
6. CNT_WIDTH=2, five stop-error frames -> stp_err_cnt=3 (saturated). A sixth bad frame with cnt_clr on the increment cycle -> stp_err_cnt=0.
